riscv_instr_feeder: RTL and testbench

Testbench-side instruction source that drives the DUT fetch port (`instruction_F`), paired with the pipeline assertion checker, which observes the same signals. A loader handshake fills an internal instruction store. The block then serves instructions either by PC lookup (preload mode) or in strict sequence (stream mode). It honours `stall` and `flush`, pads past the end of the program with NOPs, and raises `done` once the pipeline has drained.

---
 rtl/riscv_tb_pkg.sv | 7 +
 rtl/feeder_mem.sv | 18 +
 rtl/riscv_instr_feeder.sv | 83 ++++++++
 tb/tb_riscv_instr_feeder.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/riscv_tb_pkg.sv
// riscv_tb_pkg: shared types and constants for the instruction feeder
package riscv_tb_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} feeder_state_e;
  localparam logic [31:0] RV_NOP = 32'h0000_0013;
  localparam logic MODE_PRELOAD = 1'b0;
  localparam logic MODE_STREAM = 1'b1;
endpackage

// File: rtl/feeder_mem.sv
// feeder_mem: instruction store, synchronous write and asynchronous read
module feeder_mem #(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  // write port; contents survive reset
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/riscv_instr_feeder.sv
// riscv_instr_feeder: loads a program then serves it by PC or in sequence
module riscv_instr_feeder
  import riscv_tb_pkg::*;
#(
  parameter int          DEPTH = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DRAIN_CYCLES = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [31:0]              load_data,
  input  logic                     load_last,
  input  logic                     instr_mode,
  input  logic [31:0]              PC_F,
  input  logic                     stall,
  input  logic                     flush,
  output logic [31:0]              instruction_F,
  output logic                     fetch_valid,
  output logic [$clog2(DEPTH):0]   load_count,
  output logic                     done,
  output logic                     misalign_err,
  output logic                     seq_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  feeder_state_e state, state_n;
  logic mode_q;
  logic [CW-1:0] rd_ptr;
  logic [DW-1:0] drain;
  logic [31:0] idx, rdata;
  logic accept, aligned, in_range, full_next, pad, drain_hit, in_load;
  assign idx = (PC_F - BASE_ADDR) >> 2;
  assign aligned = PC_F[1:0] == 2'b00;
  assign in_range = (mode_q == MODE_STREAM) ? rd_ptr < load_count : aligned && idx < 32'(load_count);
  assign in_load = state == IDLE || state == LOAD;
  assign load_ready = !reset && in_load;
  assign accept = load_valid && load_ready;
  assign full_next = load_count == CW'(DEPTH - 1);
  assign pad = state == RUN && !in_range && !flush && !stall;
  assign drain_hit = pad && drain == DW'(DRAIN_CYCLES - 1);
  assign fetch_valid = state == RUN;
  assign done = state == DONE;
  assign instruction_F = (state == RUN && in_range) ? rdata : RV_NOP;
  feeder_mem #(.DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .we(accept),
    .waddr(load_count[AW-1:0]),
    .wdata(load_data),
    .raddr((mode_q == MODE_STREAM) ? rd_ptr[AW-1:0] : idx[AW-1:0]),
    .rdata(rdata)
  );
  // next state: load finishes on last beat or full store, run ends after drain
  always_comb begin
    state_n = state;
    state_n = (in_load && accept && (load_last || full_next)) ? RUN
            : (state == IDLE && accept) ? LOAD
            : drain_hit ? DONE : state;
  end
  // state, load counter, read pointer, drain counter and sticky errors
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      load_count <= '0;
      rd_ptr <= '0;
      drain <= '0;
      misalign_err <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) load_count <= load_count + 1'b1;
      if (state == IDLE && accept) mode_q <= instr_mode;
      if (state == RUN) begin
        if (mode_q == MODE_STREAM && !stall && !flush && rd_ptr < load_count) rd_ptr <= rd_ptr + 1'b1;
        drain <= (flush || in_range) ? '0 : stall ? drain : drain + 1'b1;
        misalign_err <= misalign_err | (mode_q == MODE_PRELOAD && !aligned);
        seq_err <= seq_err | (mode_q == MODE_STREAM && flush);
      end
    end
  end
endmodule

// File: tb/tb_riscv_instr_feeder.sv
// tb_riscv_instr_feeder: directed vector bench for the instruction feeder
module tb_riscv_instr_feeder;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0, reset = 1'b1, load_valid = 1'b0, load_last = 1'b0, instr_mode = 1'b0;
  logic stall = 1'b0, flush = 1'b0;
  logic [31:0] load_data = '0, PC_F = '0, instruction_F;
  logic load_ready, fetch_valid, done, misalign_err, seq_err;
  logic [3:0] load_count;
  int total = 0, passed = 0, n = 0;
  typedef struct {
    logic [31:0] pc;
    logic stall, flush;
    logic [31:0] instr;
    logic fv, dn;
    logic [1:0] err;
  } vec_t;
  vec_t tbl [64];

  riscv_instr_feeder #(.DEPTH(8), .BASE_ADDR(32'h0), .DRAIN_CYCLES(5)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_last(load_last), .instr_mode(instr_mode),
    .PC_F(PC_F), .stall(stall), .flush(flush), .instruction_F(instruction_F),
    .fetch_valid(fetch_valid), .load_count(load_count), .done(done),
    .misalign_err(misalign_err), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic add(input logic [31:0] pc, input logic st, input logic fl, input logic [31:0] ins,
                     input logic fv, input logic dn, input logic [1:0] err);
    tbl[n] = '{pc, st, fl, ins, fv, dn, err};
    n++;
  endtask

  task automatic run(input int lo, input int hi, input string nm);
    for (int i = lo; i < hi; i++) begin
      PC_F = tbl[i].pc;
      stall = tbl[i].stall;
      flush = tbl[i].flush;
      #1;
      chk($sformatf("%s[%0d] instr", nm, i - lo), instruction_F, tbl[i].instr);
      chk($sformatf("%s[%0d] fetch_valid", nm, i - lo), 32'(fetch_valid), 32'(tbl[i].fv));
      chk($sformatf("%s[%0d] done", nm, i - lo), 32'(done), 32'(tbl[i].dn));
      chk($sformatf("%s[%0d] err", nm, i - lo), {30'b0, seq_err, misalign_err}, 32'(tbl[i].err));
      @(negedge clk);
    end
    stall = 1'b0;
    flush = 1'b0;
  endtask

  task automatic load(input logic [31:0] base, input int cnt, input logic mode);
    for (int i = 0; i < cnt; i++) begin
      load_valid = 1'b1;
      load_data = base + 32'(i);
      load_last = (i == cnt - 1);
      instr_mode = mode;
      @(negedge clk);
    end
    load_valid = 1'b0;
    load_last = 1'b0;
    instr_mode = ~mode;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    PC_F = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int p0, s0, f0, m0, d0;
    p0 = n;
    add(0, 0, 0, 32'hA000_0000, 1, 0, 0);
    add(4, 0, 0, 32'hA000_0001, 1, 0, 0);
    add(8, 0, 0, 32'hA000_0002, 1, 0, 0);
    add(12, 0, 0, 32'hA000_0003, 1, 0, 0);
    add(16, 0, 0, NOP, 1, 0, 0);
    add(16, 0, 0, NOP, 1, 0, 0);
    add(16, 1, 0, NOP, 1, 0, 0);
    add(16, 0, 0, NOP, 1, 0, 0);
    add(16, 0, 0, NOP, 1, 0, 0);
    add(16, 0, 0, NOP, 1, 0, 0);
    add(16, 0, 0, NOP, 0, 1, 0);
    s0 = n;
    add(0, 0, 0, 32'hB000_0000, 1, 0, 0);
    add(0, 1, 0, 32'hB000_0001, 1, 0, 0);
    add(0, 1, 0, 32'hB000_0001, 1, 0, 0);
    add(0, 0, 0, 32'hB000_0001, 1, 0, 0);
    add(0, 0, 0, 32'hB000_0002, 1, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, NOP, 1, 0, 0);
    add(0, 0, 0, NOP, 0, 1, 0);
    f0 = n;
    add(0, 0, 0, 32'hC000_0000, 1, 0, 0);
    add(0, 0, 0, 32'hC000_0001, 1, 0, 0);
    add(0, 0, 1, 32'hC000_0002, 1, 0, 0);
    add(0, 0, 0, 32'hC000_0002, 1, 0, 2);
    add(0, 0, 0, NOP, 1, 0, 2);
    add(0, 0, 0, NOP, 1, 0, 2);
    add(0, 1, 1, NOP, 1, 0, 2);
    for (int i = 0; i < 5; i++) add(0, 0, 0, NOP, 1, 0, 2);
    add(0, 0, 0, NOP, 0, 1, 2);
    m0 = n;
    add(2, 0, 0, NOP, 1, 0, 0);
    add(4, 0, 0, 32'hE000_0001, 1, 0, 1);
    add(8, 0, 0, NOP, 1, 0, 1);
    d0 = n;
    add(28, 0, 0, 32'hD000_0007, 1, 0, 0);
    add(32, 0, 0, NOP, 1, 0, 0);

    @(negedge clk);
    @(negedge clk);
    chk("reset load_ready", 32'(load_ready), 0);
    chk("reset instr", instruction_F, NOP);
    chk("reset fetch_valid", 32'(fetch_valid), 0);
    chk("reset done", 32'(done), 0);
    chk("reset errs", {30'b0, seq_err, misalign_err}, 0);
    chk("reset load_count", 32'(load_count), 0);
    reset = 1'b0;
    #1 chk("idle load_ready", 32'(load_ready), 1);

    load(32'hA000_0000, 4, 1'b0);
    chk("preload load_count", 32'(load_count), 4);
    run(p0, s0, "preload");

    do_reset();
    load(32'hB000_0000, 3, 1'b1);
    run(s0, f0, "stall");

    do_reset();
    load(32'hC000_0000, 3, 1'b1);
    run(f0, m0, "flush");

    do_reset();
    for (int i = 0; i < 10; i++) begin
      load_valid = 1'b1;
      load_data = 32'hD000_0000 + 32'(i);
      load_last = 1'b0;
      instr_mode = 1'b0;
      #1 chk($sformatf("full beat%0d load_ready", i), 32'(load_ready), (i < 8) ? 1 : 0);
      @(negedge clk);
    end
    load_valid = 1'b0;
    chk("full load_count", 32'(load_count), 8);
    run(d0, n, "full");

    do_reset();
    load(32'hE000_0000, 2, 1'b0);
    run(m0, d0, "misalign");
    reset = 1'b1;
    #1 chk("midrun reset load_ready", 32'(load_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post reset instr", instruction_F, NOP);
    chk("post reset fetch_valid", 32'(fetch_valid), 0);
    chk("post reset done", 32'(done), 0);
    chk("post reset errs", {30'b0, seq_err, misalign_err}, 0);
    chk("post reset load_count", 32'(load_count), 0);
    chk("post reset load_ready", 32'(load_ready), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
